cordic_linear_pipe: RTL and testbench

- Parametrised, fully pipelined linear-mode CORDIC. Successor to the single-mode linear block.
- Runtime mode select per sample: multiply (res = a*c) or divide (res = b/a).
- Accepts one sample per clock and returns one result per clock, with a per-sample residual on the error output.
- Used as the shared mult/div arithmetic engine in the signal-processing datapath.

---
 rtl/cordic_linear_pipe.sv | 154 +++++++++++++++
 tb/tb_cordic_linear_pipe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_linear_pipe.sv
// Fully pipelined linear-mode CORDIC: per-sample multiply (a*c) or divide (b/a).
// Define CORDIC_LINEAR_SAT_EN to saturate out-of-range results and add the ovf output.
module cordic_linear_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = 15,
  parameter int unsigned GUARD = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] c,
  output logic signed [WIDTH-1:0] res,
  output logic signed [WIDTH-1:0] error,
  output logic                    done
`ifdef CORDIC_LINEAR_SAT_EN
  ,
  output logic                    ovf
`endif
);

  // Internal Q2.(WIDTH-1+GUARD) so that 1.0 is representable.
  localparam int unsigned IW  = WIDTH + 1 + GUARD;
  localparam int unsigned IW1 = IW + 1;
  localparam int unsigned FB  = WIDTH - 1 + GUARD;
`ifdef CORDIC_LINEAR_SAT_EN
  localparam int unsigned RW  = WIDTH + 2;
  localparam logic signed [WIDTH-1:0] FS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] FS_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`else
  localparam int unsigned RW  = WIDTH;
`endif
  localparam logic signed [IW:0] HALF = IW1'((1 << GUARD) >> 1);

  function automatic logic signed [IW-1:0] to_int(input logic signed [WIDTH-1:0] v);
    logic signed [IW-1:0] t;
    t = IW'(v);
    return t <<< GUARD;
  endfunction

  function automatic logic signed [IW-1:0] pow2neg(input int unsigned i);
    return {{(IW-1){1'b0}}, 1'b1} << (FB - i);
  endfunction

  // Round half up on the guard bits; result is Q3.(WIDTH-1).
  function automatic logic signed [WIDTH+1:0] rnd(input logic signed [IW-1:0] v);
    logic signed [IW:0] t;
    t = IW1'(v) + HALF;
    t = t >>> GUARD;
    return (WIDTH+2)'(t);
  endfunction

  logic signed [IW-1:0] x_q  [ITER];
  logic signed [IW-1:0] y_q  [ITER+1];
  logic signed [IW-1:0] z_q  [ITER+1];
  logic signed [IW-1:0] y_nx [ITER];
  logic signed [IW-1:0] z_nx [ITER];
  logic [ITER:0]        v_q;
  logic [ITER:0]        m_q;
  logic signed [RW-1:0]    r_q;
  logic signed [WIDTH-1:0] e_q;
  logic                    rv_q;
  logic signed [WIDTH-1:0] res_d;
  logic signed [WIDTH-1:0] err_d;
`ifdef CORDIC_LINEAR_SAT_EN
  logic [ITER:0] az_q;
  logic [ITER:0] sg_q;
  logic          raz_q;
  logic          rsg_q;
  logic          ovf_d;
`endif

  always_comb begin
    for (int i = 0; i < int'(ITER); i++) begin
      logic d_pos;
      // Divide drives y toward zero; multiply drives z toward zero.
      d_pos   = m_q[i] ? (y_q[i][IW-1] != x_q[i][IW-1]) : ~z_q[i][IW-1];
      y_nx[i] = d_pos ? y_q[i] + (x_q[i] >>> i) : y_q[i] - (x_q[i] >>> i);
      z_nx[i] = d_pos ? z_q[i] - pow2neg(i) : z_q[i] + pow2neg(i);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      m_q[0] <= mode;
      x_q[0] <= to_int(a);
      y_q[0] <= mode ? to_int(b) : '0;
      z_q[0] <= mode ? '0 : to_int(c);
`ifdef CORDIC_LINEAR_SAT_EN
      az_q[0] <= mode && (a == '0);
      sg_q[0] <= mode ? b[WIDTH-1] : (a[WIDTH-1] ^ c[WIDTH-1]);
`endif
    end
    for (int i = 0; i < int'(ITER) - 1; i++) x_q[i+1] <= x_q[i];
    for (int i = 0; i < int'(ITER); i++) begin
      y_q[i+1] <= y_nx[i];
      z_q[i+1] <= z_nx[i];
      m_q[i+1] <= m_q[i];
`ifdef CORDIC_LINEAR_SAT_EN
      az_q[i+1] <= az_q[i];
      sg_q[i+1] <= sg_q[i];
`endif
    end
    r_q <= RW'(rnd(m_q[ITER] ? z_q[ITER] : y_q[ITER]));
    e_q <= WIDTH'(rnd(m_q[ITER] ? y_q[ITER] : z_q[ITER]));
`ifdef CORDIC_LINEAR_SAT_EN
    raz_q <= az_q[ITER];
    rsg_q <= sg_q[ITER];
`endif
  end

  always_comb begin
    res_d = r_q[WIDTH-1:0];
    err_d = e_q;
`ifdef CORDIC_LINEAR_SAT_EN
    ovf_d = 1'b0;
    if (raz_q) begin
      ovf_d = 1'b1;
      res_d = rsg_q ? FS_MIN : FS_MAX;
    end else if (r_q[WIDTH+1:WIDTH-1] != {3{r_q[WIDTH-1]}}) begin
      ovf_d = 1'b1;
      res_d = r_q[WIDTH+1] ? FS_MIN : FS_MAX;
    end
    if (ovf_d) err_d = rsg_q ? FS_MIN : FS_MAX;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      rv_q  <= 1'b0;
      done  <= 1'b0;
      res   <= '0;
      error <= '0;
`ifdef CORDIC_LINEAR_SAT_EN
      ovf   <= 1'b0;
`endif
    end else begin
      v_q  <= {v_q[ITER-1:0], en};
      rv_q <= v_q[ITER];
      done <= rv_q;
      if (rv_q) begin
        res   <= res_d;
        error <= err_d;
      end
`ifdef CORDIC_LINEAR_SAT_EN
      ovf <= rv_q & ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_cordic_linear_pipe.sv
// Directed bench for cordic_linear_pipe: latency, throughput, mode mixing, bubbles,
// reset flush and out-of-range results (wrap or saturate with CORDIC_LINEAR_SAT_EN).
module tb_cordic_linear_pipe;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               en = 1'b0;
  logic               mode = 1'b0;
  logic signed [15:0] a = '0;
  logic signed [15:0] b = '0;
  logic signed [15:0] c = '0;
  logic signed [15:0] res;
  logic signed [15:0] error;
  logic               done;
`ifdef CORDIC_LINEAR_SAT_EN
  logic               ovf;
  logic               h_ovf [1024];
`endif

  logic signed [15:0] h_res  [1024];
  logic signed [15:0] h_err  [1024];
  logic               h_done [1024];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  cordic_linear_pipe #(.WIDTH(16), .ITER(15), .GUARD(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .c     (c),
    .res   (res),
    .error (error),
    .done  (done)
`ifdef CORDIC_LINEAR_SAT_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    n_tests++;
    if (obs - exp > tol || exp - obs > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // History slot k holds outputs as seen just after rising edge k.
  task automatic step();
    @(negedge clk);
    h_res[cyc % 1024]  = res;
    h_err[cyc % 1024]  = error;
    h_done[cyc % 1024] = done;
`ifdef CORDIC_LINEAR_SAT_EN
    h_ovf[cyc % 1024]  = ovf;
`endif
  endtask

  task automatic drive(input logic e, input logic m, input int av, input int bv, input int cv,
                       output int edge_n);
    en = e;
    mode = m;
    a = 16'(av);
    b = 16'(bv);
    c = 16'(cv);
    edge_n = cyc + 1;
    step();
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    int e;
    int ev [5];
    int da [5] = '{26213, 16383, 22936, 19660, -16384};
    int db [5] = '{19660, 8191, 19660, 6553, 8192};
    int dx [5] = '{24576, 16383, 28088, 10922, -16384};

    #1 rst_n = 1'b0;
    step();
    step();
    check("rst_res", res, 0, 0);
    check("rst_err", error, 0, 0);
    check("rst_done", done, 0, 0);
    rst_n = 1'b1;
    step();

    // Single divide 0.6/0.8, latency and accuracy.
    drive(1'b1, 1'b1, 26213, 19660, 0, e);
    idle(20);
    check("t1_pre", h_done[(e + 16) % 1024], 0, 0);
    check("t1_done", h_done[(e + 17) % 1024], 1, 0);
    check("t1_res", h_res[(e + 17) % 1024], 24576, 3);
    check("t1_err", h_err[(e + 17) % 1024], 0, 3);
    check("t1_post", h_done[(e + 18) % 1024], 0, 0);
`ifdef CORDIC_LINEAR_SAT_EN
    check("t1_ovf", h_ovf[(e + 17) % 1024], 0, 0);
`endif

    // Back-to-back divides, including a negative divisor.
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, da[k], db[k], 777, ev[k]);
    idle(20);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t2_done%0d", k), h_done[(ev[k] + 17) % 1024], 1, 0);
      check($sformatf("t2_res%0d", k), h_res[(ev[k] + 17) % 1024], dx[k], 3);
    end

    // Mode changes every sample; unused operand carries junk.
    drive(1'b1, 1'b0, 26213, 12345, 19660, ev[0]);
    drive(1'b1, 1'b1, 16383, 8191, -999, ev[1]);
    drive(1'b1, 1'b0, -16384, -3000, 16384, ev[2]);
    idle(20);
    check("t3_mul_res", h_res[(ev[0] + 17) % 1024], 15727, 3);
    check("t3_mul_err", h_err[(ev[0] + 17) % 1024], 0, 3);
    check("t3_div_res", h_res[(ev[1] + 17) % 1024], 16383, 3);
    check("t3_neg_res", h_res[(ev[2] + 17) % 1024], -8192, 3);
    check("t3_neg_done", h_done[(ev[2] + 17) % 1024], 1, 0);

    // Bubble between two divides; res holds through the gap.
    drive(1'b1, 1'b1, 16383, 8191, 0, ev[0]);
    drive(1'b0, 1'b0, 1, 1, 1, ev[1]);
    drive(1'b1, 1'b1, 19660, 6553, 0, ev[2]);
    idle(20);
    check("t4_done0", h_done[(ev[0] + 17) % 1024], 1, 0);
    check("t4_gap", h_done[(ev[0] + 18) % 1024], 0, 0);
    check("t4_hold", h_res[(ev[0] + 18) % 1024], 16383, 3);
    check("t4_done2", h_done[(ev[0] + 19) % 1024], 1, 0);
    check("t4_res2", h_res[(ev[0] + 19) % 1024], 10922, 3);

    // Out of range: 0.75/0.25 and divide by zero.
    drive(1'b1, 1'b1, 8191, 24575, 0, ev[0]);
    drive(1'b1, 1'b1, 0, 100, 0, ev[1]);
    idle(20);
    check("t5_done0", h_done[(ev[0] + 17) % 1024], 1, 0);
    check("t5_done1", h_done[(ev[1] + 17) % 1024], 1, 0);
`ifdef CORDIC_LINEAR_SAT_EN
    check("t5_res0", h_res[(ev[0] + 17) % 1024], 32767, 0);
    check("t5_ovf0", h_ovf[(ev[0] + 17) % 1024], 1, 0);
    check("t5_err0", h_err[(ev[0] + 17) % 1024], 32767, 0);
    check("t5_res1", h_res[(ev[1] + 17) % 1024], 32767, 0);
    check("t5_ovf1", h_ovf[(ev[1] + 17) % 1024], 1, 0);
`else
    // z sums to 2 - 2^-14, which rounds to 65534 and wraps to -2.
    check("t5_res0", h_res[(ev[0] + 17) % 1024], -2, 0);
    check("t5_err0", h_err[(ev[0] + 17) % 1024], 8196, 0);
    check("t5_res1", h_res[(ev[1] + 17) % 1024], -2, 0);
    check("t5_err1", h_err[(ev[1] + 17) % 1024], 100, 0);
`endif

    // Reset with samples in flight.
    drive(1'b1, 1'b1, 26213, 19660, 0, ev[0]);
    drive(1'b1, 1'b0, 26213, 0, 19660, ev[1]);
    drive(1'b1, 1'b1, 16383, 8191, 0, ev[2]);
    idle(2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_res", res, 0, 0);
    check("t6_rst_err", error, 0, 0);
    check("t6_rst_done", done, 0, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("t6_done%0d", k), done, 0, 0);
    end
    check("t6_res", res, 0, 0);
    check("t6_err", error, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
